// File: rtl/systolic_skew_feeder_pkg.sv
// Shared definitions for the systolic skew feeder.
// Holds the feeder state encoding and the default lane geometry.
package systolic_skew_feeder_pkg;

   localparam int DEFAULT_DATA_WIDTH = 16;
   localparam int DEFAULT_LANES      = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2,
      DRAIN  = 2'd3
   } feeder_state_e;

endpackage

// File: rtl/systolic_skew_feeder_delay.sv
// Fixed-depth shift register with async reset.
// One instance per lane provides that lane's skew.
module skew_delay_line #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [WIDTH-1:0] stage_d [DEPTH];

   always_comb begin
      stage_d[0] = d;
      for (int i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Accepts row/column vectors and presents them to a PE array edge with
// lane k delayed by k+1 cycles; appends a zero finish beat to every tile.
module systolic_skew_feeder
   import systolic_skew_feeder_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int LANES      = DEFAULT_LANES
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [LANES*DATA_WIDTH-1:0] in_data,
   input  logic                        in_last,
   output logic [LANES*DATA_WIDTH-1:0] out_data,
   output logic [LANES-1:0]            out_finish,
   output logic                        busy,
   output logic [7:0]                  tile_count,
   output feeder_state_e               dbg_state
);

   localparam int CNT_W = (LANES > 2) ? $clog2(LANES) : 1;
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(LANES - 2);

   // Handshake: a beat transfers on any cycle where in_valid && in_ready.
   // in_ready does not depend on in_valid, and upstream must hold its beat
   // stable until it transfers.

   feeder_state_e          state_q, state_d;
   logic [CNT_W-1:0]       drain_cnt_q, drain_cnt_d;
   logic [7:0]             tile_count_q, tile_count_d;
   logic                   accept;
   logic [LANES*DATA_WIDTH-1:0] stage0_data;
   logic                   stage0_finish;

   assign in_ready = !rst && ((state_q == IDLE) || (state_q == STREAM));
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d      = state_q;
      drain_cnt_d  = drain_cnt_q;
      tile_count_d = tile_count_q;
      case (state_q)
         IDLE: begin
            if (accept) state_d = in_last ? FLUSH : STREAM;
         end
         STREAM: begin
            if (accept && in_last) state_d = FLUSH;
         end
         FLUSH: begin
            state_d      = DRAIN;
            drain_cnt_d  = '0;
            tile_count_d = tile_count_q + 8'd1;
         end
         DRAIN: begin
            if (drain_cnt_q == DRAIN_LAST) state_d = IDLE;
            else drain_cnt_d = drain_cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         drain_cnt_q  <= '0;
         tile_count_q <= '0;
      end else begin
         state_q      <= state_d;
         drain_cnt_q  <= drain_cnt_d;
         tile_count_q <= tile_count_d;
      end
   end

   // Idle and gap cycles inject zeros so PEs accumulate nothing.
   assign stage0_data   = accept ? in_data : '0;
   assign stage0_finish = (state_q == FLUSH);

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [DATA_WIDTH:0] lane_q;
      skew_delay_line #(
         .WIDTH (DATA_WIDTH + 1),
         .DEPTH (k + 1)
      ) u_delay (
         .clk (clk),
         .rst (rst),
         .d   ({stage0_finish, stage0_data[k*DATA_WIDTH +: DATA_WIDTH]}),
         .q   (lane_q)
      );
      assign out_data[k*DATA_WIDTH +: DATA_WIDTH] = lane_q[DATA_WIDTH-1:0];
      assign out_finish[k]                        = lane_q[DATA_WIDTH];
   end

   assign busy       = (state_q != IDLE);
   assign tile_count = tile_count_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed and randomized checks of the skew feeder against a cycle-indexed
// history model, plus an identity-matrix run through a small PE array model.
module tb_systolic_skew_feeder;
   import systolic_skew_feeder_pkg::*;

   localparam int DW = 16;
   localparam int L  = 4;
   localparam int W  = DW * L;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready, in_ready_b;
   logic [W-1:0]  in_data, in_data_b;
   logic          in_last;
   logic [W-1:0]  out_data, out_data_b;
   logic [L-1:0]  out_finish, out_finish_b;
   logic          busy, busy_b;
   logic [7:0]    tile_count, tile_count_b;
   feeder_state_e dbg_state, dbg_state_b;

   systolic_skew_feeder #(.DATA_WIDTH(DW), .LANES(L)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .out_data(out_data),
      .out_finish(out_finish), .busy(busy), .tile_count(tile_count),
      .dbg_state(dbg_state)
   );

   systolic_skew_feeder #(.DATA_WIDTH(DW), .LANES(L)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_data(in_data_b), .in_last(in_last), .out_data(out_data_b),
      .out_finish(out_finish_b), .busy(busy_b), .tile_count(tile_count_b),
      .dbg_state(dbg_state_b)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: stage-0 content recorded per cycle number since reset.
   int           t;
   int           end_cyc;
   bit           in_tile;
   int           tiles;
   logic [W-1:0] hist_d[$];
   logic         hist_f[$];

   int pe_a[L][L], pe_b[L][L], pe_acc[L][L];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      t = 0;
      end_cyc = -100;
      in_tile = 0;
      tiles = 0;
      hist_d.delete();
      hist_f.delete();
   endtask

   // Not ready during the 1 flush cycle and LANES-1 drain cycles after a last beat.
   function automatic bit exp_ready();
      return !((t >= end_cyc + 1) && (t <= end_cyc + L));
   endfunction

   task automatic check_outputs();
      logic [W-1:0] hv;
      logic         hf;
      for (int k = 0; k < L; k++) begin
         int idx = t - k - 1;
         hv = '0;
         hf = 1'b0;
         if (idx >= 0) begin
            hv = hist_d[idx];
            hf = hist_f[idx];
         end
         chk($sformatf("lane%0d_data", k), 64'(out_data[k*DW +: DW]), 64'(hv[k*DW +: DW]));
         chk($sformatf("lane%0d_finish", k), 64'(out_finish[k]), 64'(hf));
      end
      chk("tile_count", 64'(tile_count), 64'(tiles % 256));
   endtask

   task automatic step(input bit v, input logic [W-1:0] d, input bit l, output bit acc);
      bit rdy, fin;
      in_valid = v;
      in_data  = d;
      in_last  = l;
      rdy = exp_ready();
      fin = (t == end_cyc + 1);
      @(negedge clk);
      chk("in_ready", 64'(in_ready), 64'(rdy));
      chk("busy", 64'(busy), 64'(in_tile || !rdy));
      acc = v && rdy;
      hist_d.push_back(acc ? d : '0);
      hist_f.push_back(fin);
      if (acc) begin
         if (l) begin
            end_cyc = t;
            in_tile = 0;
         end else begin
            in_tile = 1;
         end
      end
      if (fin) tiles++;
      @(posedge clk);
      #1;
      t++;
      check_outputs();
   endtask

   task automatic send(input logic [W-1:0] d, input bit l, output int stalls);
      bit acc;
      stalls = 0;
      acc = 0;
      while (!acc && stalls < 20) begin
         step(1'b1, d, l, acc);
         if (!acc) stalls++;
      end
      chk("send_accepted", 64'(acc), 64'd1);
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) step(1'b0, {$urandom, $urandom}, 1'($urandom_range(0, 1)), acc);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      in_last = 1'b0;
      #1;
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_finish", 64'(out_finish), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_tile_count", 64'(tile_count), 64'd0);
      chk("rst_state", 64'(dbg_state), 64'(IDLE));
      @(posedge clk);
      #1;
      chk("rst_in_ready_hold", 64'(in_ready), 64'd0);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic pe_step();
      int na[L][L], nb[L][L];
      int ain, bin;
      for (int i = 0; i < L; i++) begin
         for (int j = 0; j < L; j++) begin
            ain = (j == 0) ? int'(out_data[i*DW +: DW]) : pe_a[i][j-1];
            bin = (i == 0) ? int'(out_data_b[j*DW +: DW]) : pe_b[i-1][j];
            pe_acc[i][j] += (ain * bin) >>> 8;
            na[i][j] = ain;
            nb[i][j] = bin;
         end
      end
      pe_a = na;
      pe_b = nb;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int stalls;
      bit acc;
      logic [W-1:0] v;
      rst = 1'b1;
      in_valid = 1'b0;
      in_last = 1'b0;
      in_data = '0;
      in_data_b = '0;
      @(posedge clk);
      #1;
      do_reset();

      // Single tile {1,2,3,4} then {5,6,7,8} with last.
      send({16'd4, 16'd3, 16'd2, 16'd1}, 1'b0, stalls);
      send({16'd8, 16'd7, 16'd6, 16'd5}, 1'b1, stalls);
      idle(6);
      chk("single_tile_count", 64'(tile_count), 64'd1);

      // Gap of two cycles mid-tile.
      send({$urandom, $urandom}, 1'b0, stalls);
      idle(2);
      send({$urandom, $urandom}, 1'b1, stalls);
      idle(6);

      // Backpressure: next tile held valid through flush and drain.
      send({$urandom, $urandom}, 1'b1, stalls);
      send({$urandom, $urandom}, 1'b0, stalls);
      chk("bp_stall_cycles", 64'(stalls), 64'd4);
      send({$urandom, $urandom}, 1'b1, stalls);
      idle(6);

      // Randomized tiles with random gaps.
      for (int n = 0; n < 12; n++) begin
         int len = $urandom_range(1, 5);
         for (int b = 0; b < len; b++) begin
            idle($urandom_range(0, 2));
            send({$urandom, $urandom}, b == len - 1, stalls);
         end
      end
      idle(6);

      // 256 back-to-back single-beat tiles: counter wraps.
      do_reset();
      for (int n = 0; n < 256; n++) send({$urandom, $urandom}, 1'b1, stalls);
      idle(6);
      chk("tile_wrap", 64'(tile_count), 64'd0);

      // Reset while finish pulses are still in the skew lines.
      send({$urandom, $urandom}, 1'b0, stalls);
      send({$urandom, $urandom}, 1'b1, stalls);
      idle(2);
      chk("pre_rst_state", 64'(dbg_state), 64'(DRAIN));
      do_reset();
      idle(8);

      // Identity x identity (8-bit fraction) through a 4x4 PE model.
      do_reset();
      for (int i = 0; i < L; i++)
         for (int j = 0; j < L; j++) begin
            pe_a[i][j] = 0;
            pe_b[i][j] = 0;
            pe_acc[i][j] = 0;
         end
      for (int k = 0; k < L; k++) begin
         v = '0;
         v[k*DW +: DW] = 16'd256;
         in_data_b = v;
         step(1'b1, v, k == L - 1, acc);
         pe_step();
      end
      in_data_b = '0;
      for (int c = 0; c < 14; c++) begin
         step(1'b0, '0, 1'b0, acc);
         pe_step();
      end
      for (int i = 0; i < L; i++)
         for (int j = 0; j < L; j++)
            chk($sformatf("pe_result_%0d_%0d", i, j), 64'(pe_acc[i][j]), (i == j) ? 64'd256 : 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/systolic_skew_feeder.md
SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the width of one lane element.
REQ-002 Parameter LANES, default 4, SHALL set the number of PE rows/columns fed, with LANES >= 2.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1 bit, SHALL mark in_data as a valid input vector.
REQ-006 Port in_ready, output, 1 bit, SHALL mark that the feeder accepts a vector this cycle.
REQ-007 Port in_data, input, LANES*DATA_WIDTH bits, SHALL carry one vector, with lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 Port in_last, input, 1 bit, SHALL mark the accepted vector as the final beat of a tile.
REQ-009 Port out_data, output, LANES*DATA_WIDTH bits, SHALL carry the skewed lane values driving the PE edge inputs (i_left/i_up).
REQ-010 Port out_finish, output, LANES bits, SHALL carry the per-lane finish pulse driving the PE finish inputs.
REQ-011 Port busy, output, 1 bit, SHALL be high whenever state is not IDLE.
REQ-012 Port tile_count, output, 8 bits, SHALL count completed tiles and wrap from 255 to 0.

Function
REQ-013 A beat SHALL be accepted exactly when in_valid && in_ready.
REQ-014 The state machine SHALL have states IDLE, STREAM, FLUSH and DRAIN.
REQ-015 In IDLE and STREAM, in_ready SHALL be 1; in FLUSH and DRAIN, in_ready SHALL be 0.
REQ-016 From IDLE, an accepted beat SHALL move the state to STREAM, or to FLUSH if in_last = 1.
REQ-017 In STREAM, an accepted beat with in_last = 1 SHALL move the state to FLUSH.
REQ-018 FLUSH SHALL last exactly 1 cycle and SHALL inject a zero vector with the finish flag set, then move to DRAIN.
REQ-019 DRAIN SHALL last exactly LANES-1 cycles, counted by an internal counter, then move to IDLE.
REQ-020 tile_count SHALL increment on the cycle FLUSH is exited.
REQ-021 Stage-0 vector: the accepted in_data SHALL be used when a beat is accepted.
REQ-022 Otherwise the stage-0 vector SHALL be all zeros, so that gaps add 0 to PE accumulation.
REQ-023 Stage-0 finish SHALL be 1 only in FLUSH.
REQ-024 out_data lane k SHALL equal stage-0 lane k delayed by k+1 clock cycles, so lane 0 has 1-cycle latency.
REQ-025 out_finish[k] SHALL equal stage-0 finish delayed by k+1 clock cycles.
REQ-026 Data SHALL pass through unmodified, with no arithmetic and no width change.
REQ-027 There SHALL be no downstream backpressure; skew registers SHALL shift every cycle.
REQ-028 An in_valid beat while in_ready = 0 SHALL be ignored; upstream holds it until in_ready = 1.
REQ-029 A next tile SHALL be accepted in the first IDLE cycle after DRAIN; no vector of the next tile shall ever share a lane cycle with the previous finish.

Reset
REQ-030 Asserting rst SHALL immediately set the state to IDLE and clear all skew registers, out_data, out_finish, tile_count and the DRAIN counter to 0.
REQ-031 While rst is high, busy SHALL be 0 and in_ready SHALL be 0.
REQ-032 Reset asserted mid-tile SHALL discard any in-flight data and finish, with no partial finish emitted after release.
REQ-033 Operation SHALL resume in IDLE on the first rising clk edge after rst deasserts.

Structure
REQ-034 State encoding (IDLE/STREAM/FLUSH/DRAIN) and default DATA_WIDTH/LANES SHALL reside in the shared systolic package.
REQ-035 Each lane's delay line SHALL be one instance of sub-module skew_delay_line, with parameters DATA_WIDTH+1 (data plus finish) and depth k+1, async-reset.
REQ-036 The FSM, counters and handshake SHALL live in systolic_skew_feeder.

Verification (LANES=4, DATA_WIDTH=16)
REQ-037 Single tile:
- Stimulus: vectors {1,2,3,4} then {5,6,7,8} with in_last on the 2nd.
- Required response: lane k shows 1+k at cycle k+1 and 5+k at cycle k+2.
- Then out_finish[k] = 1 at cycle k+3, and tile_count = 1.
REQ-038 Gap insertion:
- Stimulus: in_valid low for 2 cycles mid-tile.
- Required response: all lanes show 0 in the corresponding skewed slots, and the finish position shifts by 2.
REQ-039 Backpressure:
- Stimulus: in_valid held high with a new tile during FLUSH/DRAIN.
- Required response: in_ready = 0 for 1+3 cycles, and the new tile's first beat is accepted in IDLE.
REQ-040 Back-to-back single-beat tiles:
- Stimulus: in_last on every beat, 256 tiles.
- Required response: tile_count wraps to 0, and each finish is spaced 5 cycles apart on each lane.
REQ-041 Reset mid-DRAIN:
- Stimulus: assert rst asynchronously.
- Required response: out_data and out_finish are 0 immediately, and no finish pulse appears after release.
REQ-042 End-to-end check:
- Stimulus: feed 4x4 PE model with A = B = identity, scaled by 256 for an 8-bit fraction.
- Required response: the diagonal o_result = 256 and off-diagonal = 0.
